// File: rtl/mem_port_arbiter_pkg.sv
// Shared core types: memory-port arbiter FSM states and port owner encoding.
package riscv_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_sel.sv
// Owner select for the memory-port arbiter: DM over IF, optional IF starvation
// guard enabled by ARB_STARVE_GUARD_EN.
module mem_arb_sel
    import riscv_types::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_arb,
    input  logic       i_if_req,
    input  logic       i_dm_req,
    input  logic       i_if_gnt,
    input  logic       i_dm_gnt,
    output arb_owner_t o_owner
);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_STARVE + 1);

    logic [CW-1:0] r_starve;
    logic          w_force_if;

    assign w_force_if = i_if_req && (r_starve == CW'(MAX_STARVE));

    // Counts DM wins that left IF waiting; saturates at the forcing threshold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (i_if_gnt) begin
            r_starve <= '0;
        end else if (i_dm_gnt && i_if_req && (r_starve != CW'(MAX_STARVE))) begin
            r_starve <= r_starve + CW'(1);
        end else if (i_arb && !i_if_req) begin
            r_starve <= '0;
        end
    end

    always_comb begin
        o_owner = OWN_DM;
        if (w_force_if) begin
            o_owner = OWN_IF;
        end else if (i_if_req && !i_dm_req) begin
            o_owner = OWN_IF;
        end
    end
`else
    logic w_unused;

    assign o_owner  = (i_if_req && !i_dm_req) ? OWN_IF : OWN_DM;
    assign w_unused = ^{clk, reset_n, i_arb, i_if_gnt, i_dm_gnt};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (DM), one transaction
// in flight. IF starvation guard enabled by ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import riscv_types::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [DW/8-1:0] dm_be_i,
    input  logic [AW-1:0]   dm_addr_i,
    input  logic [DW-1:0]   dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [DW-1:0]   dm_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            busy_o
);

    localparam int BW = DW / 8;

    arb_state_t      r_state, w_state_nxt;
    arb_owner_t      r_owner, w_sel_owner, w_owner;
    logic            r_we;
    logic [BW-1:0]   r_be;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            w_any_req, w_arb, w_gnt, w_if_gnt, w_dm_gnt;
    logic            w_pl_we;
    logic [BW-1:0]   w_pl_be;
    logic [AW-1:0]   w_pl_addr;
    logic [DW-1:0]   w_pl_wdata;

    // Requests are masked during reset so every control output reads 0.
    assign w_any_req = reset_n && (if_req_i || dm_req_i);
    assign w_arb     = (r_state == ARB_IDLE) && w_any_req;

    mem_arb_sel #(
        .MAX_STARVE(MAX_STARVE)
    ) u_sel (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_arb    (w_arb),
        .i_if_req (if_req_i),
        .i_dm_req (dm_req_i),
        .i_if_gnt (w_if_gnt),
        .i_dm_gnt (w_dm_gnt),
        .o_owner  (w_sel_owner)
    );

    assign w_pl_we    = (w_sel_owner == OWN_DM) ? dm_we_i    : 1'b0;
    assign w_pl_be    = (w_sel_owner == OWN_DM) ? dm_be_i    : '1;
    assign w_pl_addr  = (w_sel_owner == OWN_DM) ? dm_addr_i  : if_addr_i;
    assign w_pl_wdata = (w_sel_owner == OWN_DM) ? dm_wdata_i : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_DM;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb) begin
                r_owner <= w_sel_owner;
            end
        end
    end

    // Payload snapshot keeps REQ stable even if a requester misbehaves.
    always_ff @(posedge clk) begin
        if (w_arb) begin
            r_we    <= w_pl_we;
            r_be    <= w_pl_be;
            r_addr  <= w_pl_addr;
            r_wdata <= w_pl_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner     = r_owner;
        w_gnt       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_owner     = w_sel_owner;
                    mem_req_o   = 1'b1;
                    mem_we_o    = w_pl_we;
                    mem_be_o    = w_pl_be;
                    mem_addr_o  = w_pl_addr;
                    mem_wdata_o = w_pl_wdata;
                    w_gnt       = mem_gnt_i;
                    w_state_nxt = mem_gnt_i ? ARB_RESP : ARB_REQ;
                end
            end
            ARB_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = r_we;
                mem_be_o    = r_be;
                mem_addr_o  = r_addr;
                mem_wdata_o = r_wdata;
                w_gnt       = mem_gnt_i;
                if (mem_gnt_i) begin
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (mem_rvalid_i) begin
                    if_rvalid_o = (r_owner == OWN_IF);
                    dm_rvalid_o = (r_owner == OWN_DM);
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign w_if_gnt   = w_gnt && (w_owner == OWN_IF);
    assign w_dm_gnt   = w_gnt && (w_owner == OWN_DM);
    assign if_gnt_o   = w_if_gnt;
    assign dm_gnt_o   = w_dm_gnt;
    assign if_rdata_o = mem_rdata_i;
    assign dm_rdata_o = mem_rdata_i;
    assign busy_o     = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; guard expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            if_req_i;
    logic [AW-1:0]   if_addr_i;
    logic            if_gnt_o, if_rvalid_o;
    logic [DW-1:0]   if_rdata_o;
    logic            dm_req_i, dm_we_i;
    logic [DW/8-1:0] dm_be_i;
    logic [AW-1:0]   dm_addr_i;
    logic [DW-1:0]   dm_wdata_i;
    logic            dm_gnt_o, dm_rvalid_o;
    logic [DW-1:0]   dm_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [DW/8-1:0] mem_be_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0]   mem_rdata_i;
    logic            busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DM-vs-IF arbitration granted in IDLE, then an immediate response.
    task automatic xact(output logic got_if, output logic got_dm);
        mem_gnt_i = 1'b1;
        #1;
        got_if = if_gnt_o;
        got_dm = dm_gnt_o;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    logic g_if, g_dm;
    int   first_if;

    initial begin
        reset_n = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hA5A5_5A5A;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_memreq", mem_req_o, 0);
        check("rst_gnts", {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}, 0);
        check("rst_rdata_pass", if_rdata_o, 32'hA5A5_5A5A);
        reset_n = 1'b1;

        // IF alone, granted same cycle, data two cycles later
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
        #1;
        check("t1_if_gnt", if_gnt_o, 1);
        check("t1_dm_gnt", dm_gnt_o, 0);
        check("t1_addr", mem_addr_o, 32'h100);
        check("t1_we_be", {mem_we_o, mem_be_o}, 5'b0_1111);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        check("t1_resp_busy_req", {busy_o, mem_req_o, if_rvalid_o}, 3'b100);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        check("t1_rvalid", {if_rvalid_o, dm_rvalid_o}, 2'b10);
        check("t1_rdata", if_rdata_o, 32'hDEAD_BEEF);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        check("t1_idle", busy_o, 0);

        // Simultaneous requests: DM store first, IF after one idle cycle
        if_req_i = 1'b1; if_addr_i = 32'h104;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_addr_i = 32'h200; dm_wdata_i = 32'h1234;
        mem_gnt_i = 1'b1;
        #1;
        check("t2_gnts", {dm_gnt_o, if_gnt_o}, 2'b10);
        check("t2_store", {mem_we_o, mem_be_o}, 5'b1_0011);
        check("t2_addr", mem_addr_o, 32'h200);
        check("t2_wdata", mem_wdata_o, 32'h1234);
        tick();
        dm_req_i = 1'b0; dm_we_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        check("t2_resp_no_if", {if_gnt_o, mem_req_o}, 2'b00);
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        check("t2_store_ack", {dm_rvalid_o, if_rvalid_o}, 2'b10);
        tick();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        check("t2_if_after_bubble", {if_gnt_o, dm_gnt_o}, 2'b10);
        check("t2_if_addr", mem_addr_o, 32'h104);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        check("t2_if_rvalid", if_rvalid_o, 1);
        tick();
        mem_rvalid_i = 1'b0;

        // Stalled DM keeps the port; IF waits, dropped req keeps latched payload
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'b1111; dm_addr_i = 32'h300;
        #1;
        check("t3_c0_addr", mem_addr_o, 32'h300);
        check("t3_c0_nognt", dm_gnt_o, 0);
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h108;
        #1;
        check("t3_c1_addr", mem_addr_o, 32'h300);
        check("t3_c1_if_nognt", {if_gnt_o, mem_req_o}, 2'b01);
        tick();
        dm_req_i = 1'b0; dm_addr_i = 32'h999;
        #1;
        check("t3_c2_latched", mem_addr_o, 32'h300);
        tick();
        mem_gnt_i = 1'b1;
        #1;
        check("t3_c3_gnt", {dm_gnt_o, if_gnt_o}, 2'b10);
        check("t3_c3_addr", mem_addr_o, 32'h300);
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        check("t3_dm_rvalid", {dm_rvalid_o, if_rvalid_o}, 2'b10);
        tick();
        mem_rvalid_i = 1'b0;
        xact(g_if, g_dm);
        check("t3_if_after", {g_if, g_dm}, 2'b10);
        if_req_i = 1'b0;
        tick();

        // Back-to-back DM with IF waiting: starvation guard behaviour
        if_req_i = 1'b1; if_addr_i = 32'h10C;
        dm_req_i = 1'b1; dm_addr_i = 32'h400;
        first_if = 0;
        for (int k = 1; k <= 6; k++) begin
            xact(g_if, g_dm);
            if (g_if && first_if == 0) first_if = k;
        end
`ifdef ARB_STARVE_GUARD_EN
        check("t4_guard_if_arb", first_if, 5);
`else
        check("t4_strict_no_if", first_if, 0);
`endif
        dm_req_i = 1'b0;
        xact(g_if, g_dm);
        check("t4_if_when_dm_idle", {g_if, g_dm}, 2'b10);
        if_req_i = 1'b0;
        tick();

        // Stray responses and reset during RESP
        mem_rvalid_i = 1'b1;
        #1;
        check("t5_stray_idle", {if_rvalid_o, dm_rvalid_o}, 2'b00);
        tick();
        mem_rvalid_i = 1'b0; dm_req_i = 1'b1; dm_addr_i = 32'h500;
        tick();
        dm_req_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        check("t5_stray_req", {dm_rvalid_o, busy_o, mem_req_o}, 3'b011);
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        #1;
        check("t5_in_resp", busy_o, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", busy_o, 0);
        #2;
        reset_n = 1'b1;
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        check("t5_late_rvalid", {dm_rvalid_o, if_rvalid_o}, 2'b00);
        tick();
        mem_rvalid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
